// File: rtl/uart_baud_gen_frac.sv
// Fractional-N UART baud generator: oversample, bit and mid-bit ticks with glitch-free divisor update.
// Optional fractional accumulator enabled by defining UART_BAUD_FRAC_EN.
module uart_baud_gen_frac #(
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4,
    parameter int OVS        = 16,
    parameter int RESET_INT  = 325,
    parameter int RESET_FRAC = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [DIV_W-1:0]        div_int,
    input  logic [FRAC_W-1:0]       div_frac,
    input  logic                    cfg_load,
    input  logic                    resync,
    output logic                    os_tick,
    output logic                    bit_tick,
    output logic                    mid_tick,
    output logic [$clog2(OVS)-1:0]  os_phase,
    output logic                    cfg_ack
);

    localparam int                PH_W     = $clog2(OVS);
    localparam logic [DIV_W-1:0]  RST_INT  = DIV_W'(RESET_INT);
    localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(RESET_FRAC);
    localparam logic [PH_W-1:0]   PH_MID   = PH_W'(OVS / 2);
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(OVS - 1);

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        logic [DIV_W-1:0] r;
        if (d < DIV_W'(2)) begin
            r = DIV_W'(2);
        end else begin
            r = d;
        end
        return r;
    endfunction

    logic [DIV_W-1:0]  cnt_r;
    logic [DIV_W-1:0]  act_int_r;
    logic [DIV_W-1:0]  pend_int_r;
    logic [FRAC_W-1:0] act_frac_r;
    logic [FRAC_W-1:0] pend_frac_r;
    logic              pend_valid_r;
    logic              ext_s;
    logic              terminal_s;
    logic              wrap_s;
    logic              apply_s;
    logic [DIV_W-1:0]  new_int_s;
    logic [FRAC_W-1:0] new_frac_s;
    logic [PH_W-1:0]   phase_next_s;
    logic [DIV_W:0]    limit_s;

    // Terminal detection, phase advance and divisor-apply decision
    always_comb begin
        new_int_s    = pend_int_r;
        new_frac_s   = pend_frac_r;
        if (cfg_load) begin
            new_int_s  = clamp_div(div_int);
            new_frac_s = div_frac;
        end else begin
            new_int_s  = pend_int_r;
            new_frac_s = pend_frac_r;
        end
        // >= rather than == so a divisor shrunk while frozen cannot strand the counter
        limit_s      = {1'b0, act_int_r} - (DIV_W + 1)'(1) + {{DIV_W{1'b0}}, ext_s};
        terminal_s   = en && !resync && ({1'b0, cnt_r} >= limit_s);
        phase_next_s = os_phase + PH_W'(1);
        wrap_s       = terminal_s && (os_phase == PH_LAST);
        apply_s      = (pend_valid_r || cfg_load) && (resync || !en || wrap_s);
    end

    // Period counter, oversample phase and registered tick outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= DIV_W'(0);
            os_phase <= PH_W'(0);
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
            mid_tick <= 1'b0;
            cfg_ack  <= 1'b0;
        end else begin
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
            mid_tick <= 1'b0;
            cfg_ack  <= apply_s;
            if (resync) begin
                cnt_r    <= DIV_W'(0);
                os_phase <= PH_W'(0);
            end else if (en) begin
                if (terminal_s) begin
                    cnt_r    <= DIV_W'(0);
                    os_phase <= phase_next_s;
                    os_tick  <= 1'b1;
                    bit_tick <= (phase_next_s == PH_W'(0));
                    mid_tick <= (phase_next_s == PH_MID);
                end else begin
                    cnt_r <= cnt_r + DIV_W'(1);
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Pending/active divisor registers; a load coinciding with apply goes straight to active
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_int_r    <= RST_INT;
            act_frac_r   <= RST_FRAC;
            pend_int_r   <= RST_INT;
            pend_frac_r  <= RST_FRAC;
            pend_valid_r <= 1'b0;
        end else begin
            if (cfg_load) begin
                pend_int_r  <= new_int_s;
                pend_frac_r <= new_frac_s;
            end else begin
                pend_int_r  <= pend_int_r;
                pend_frac_r <= pend_frac_r;
            end
            if (apply_s) begin
                act_int_r    <= new_int_s;
                act_frac_r   <= new_frac_s;
                pend_valid_r <= 1'b0;
            end else if (cfg_load) begin
                pend_valid_r <= 1'b1;
            end else begin
                pend_valid_r <= pend_valid_r;
            end
        end
    end

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc_r;
    logic              ext_r;
    logic [FRAC_W:0]   sum_s;

    assign sum_s = {1'b0, acc_r} + {1'b0, act_frac_r};
    assign ext_s = ext_r;

    // Fractional accumulator; its carry stretches the following period by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= FRAC_W'(0);
            ext_r <= 1'b0;
        end else if (resync || apply_s) begin
            acc_r <= FRAC_W'(0);
            ext_r <= 1'b0;
        end else if (terminal_s) begin
            acc_r <= sum_s[FRAC_W-1:0];
            ext_r <= sum_s[FRAC_W];
        end else begin
            acc_r <= acc_r;
            ext_r <= ext_r;
        end
    end
`else
    logic frac_unused_s;

    assign ext_s         = 1'b0;
    assign frac_unused_s = ^act_frac_r;
`endif

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Randomized and directed bench for uart_baud_gen_frac against a period-list reference model.
module tb_uart_baud_gen_frac;

    localparam int DIV_W = 16;
    localparam int FRAC_W = 4;
    localparam int OVS = 16;
    localparam int RESET_INT = 325;
    localparam int RESET_FRAC = 8;
`ifdef UART_BAUD_FRAC_EN
    localparam bit FRAC_ON = 1'b1;
`else
    localparam bit FRAC_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [DIV_W-1:0]  div_int = '0;
    logic [FRAC_W-1:0] div_frac = '0;
    logic              cfg_load = 1'b0;
    logic              resync = 1'b0;
    logic              os_tick, bit_tick, mid_tick, cfg_ack;
    logic [3:0]        os_phase;

    uart_baud_gen_frac #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS),
        .RESET_INT(RESET_INT), .RESET_FRAC(RESET_FRAC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .div_int(div_int), .div_frac(div_frac),
        .cfg_load(cfg_load), .resync(resync), .os_tick(os_tick), .bit_tick(bit_tick),
        .mid_tick(mid_tick), .os_phase(os_phase), .cfg_ack(cfg_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    // Reference model: active/pending divisor, period index since last clear, cycles into period
    int m_int, m_frac, p_int, p_frac, n_per, elapsed, phase;
    bit p_valid;
    bit e_os, e_bit, e_mid, e_ack;

    function automatic int clamp(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    // Extra cycle of period n: how often the running sum n*frac crosses a whole cycle
    function automatic int ext_of(input int n, input int f);
        if (!FRAC_ON || n == 0) return 0;
        return (n * f) / (2 ** FRAC_W) - ((n - 1) * f) / (2 ** FRAC_W);
    endfunction

    task automatic model_reset();
        m_int = RESET_INT; m_frac = RESET_FRAC % (2 ** FRAC_W);
        p_int = m_int; p_frac = m_frac; p_valid = 1'b0;
        n_per = 0; elapsed = 0; phase = 0;
        e_os = 1'b0; e_bit = 1'b0; e_mid = 1'b0; e_ack = 1'b0;
    endtask

    task automatic model_step();
        int  eff_int, eff_frac;
        bit  eff_valid, wrap;
        if (!rst_n) begin
            model_reset();
            return;
        end
        eff_int   = cfg_load ? clamp(int'(div_int)) : p_int;
        eff_frac  = cfg_load ? int'(div_frac) : p_frac;
        eff_valid = p_valid || cfg_load;
        if (cfg_load) begin
            p_int = eff_int; p_frac = eff_frac; p_valid = 1'b1;
        end
        e_os = 1'b0; e_bit = 1'b0; e_mid = 1'b0; e_ack = 1'b0; wrap = 1'b0;
        if (resync) begin
            elapsed = 0; n_per = 0; phase = 0;
        end else if (en) begin
            if (elapsed + 1 >= m_int + ext_of(n_per, m_frac)) begin
                elapsed = 0;
                phase = (phase + 1) % OVS;
                e_os = 1'b1;
                e_bit = (phase == 0);
                e_mid = (phase == OVS / 2);
                wrap = (phase == 0);
                n_per++;
            end else begin
                elapsed++;
            end
        end
        if (eff_valid && (resync || !en || wrap)) begin
            m_int = eff_int; m_frac = eff_frac; p_valid = 1'b0; e_ack = 1'b1; n_per = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model
    initial begin
        logic [7:0] exp_v;
        forever begin
            @(negedge clk);
            exp_v = {e_os, e_bit, e_mid, e_ack, 4'(phase)};
            check_val("cycle", {24'd0, os_tick, bit_tick, mid_tick, cfg_ack, os_phase}, {24'd0, exp_v});
        end
    end

    // Wait (bounded) for the next os_tick; returns the number of clock edges it took
    task automatic wait_os(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!os_tick && n < 2000);
        if (!os_tick) check_val("os_tick_timeout", 32'(n), 32'd0);
    endtask

    task automatic load_cfg(input int di, input int df, input bit do_resync);
        @(negedge clk);
        div_int = 16'(di); div_frac = 4'(df); cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        resync = do_resync;
        @(negedge clk);
        resync = 1'b0;
    endtask

    initial begin
        int n, cnt, sum;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;

        // Defaults: first tick after RESET_INT cycles, bit on 16th, mid on 8th
        for (int k = 1; k <= 16; k++) begin
            wait_os(n);
            if (k == 1) check_val("first_tick_gap", 32'(n), 32'd325);
            check_val("dflt_bit", {31'd0, bit_tick}, {31'd0, (k == 16)});
            check_val("dflt_mid", {31'd0, mid_tick}, {31'd0, (k == 8)});
        end

        // Integer divisor 4 applied by resync
        load_cfg(4, 0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            wait_os(n);
            if (k >= 2) check_val("div4_gap", 32'(n), 32'd4);
            if (k == 16) check_val("div4_bit", {31'd0, bit_tick}, 32'd1);
        end

        // Fractional 4 + 8/16
        load_cfg(4, 8, 1'b1);
        sum = 0;
        for (int k = 1; k <= 11; k++) begin
            wait_os(n);
            if (k <= 3) check_val("frac_gap", 32'(n), (k == 3 && FRAC_ON) ? 32'd5 : 32'd4);
            if (k >= 4) sum += n;
        end
        check_val("frac_sum8", 32'(sum), FRAC_ON ? 32'd36 : 32'd32);

        // Mid-bit reload to 6: old spacing until the bit wrap
        load_cfg(4, 0, 1'b1);
        repeat (5) wait_os(n);
        @(negedge clk);
        div_int = 16'd6; div_frac = 4'd0; cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        wait_os(n);
        for (int k = 7; k <= 18; k++) begin
            wait_os(n);
            check_val("reload_gap", 32'(n), (k <= 16) ? 32'd4 : 32'd6);
            if (k == 16) check_val("reload_bit", {31'd0, bit_tick}, 32'd1);
        end

        // Freeze at cnt=2 for 10 cycles
        repeat (2) @(negedge clk);
        en = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check_val("frozen_tick", {31'd0, os_tick}, 32'd0);
        end
        en = 1'b1;
        wait_os(n);
        check_val("unfreeze_gap", 32'(n), 32'd4);

        // Resync at phase 5
        for (int k = 0; k < 40 && os_phase != 4'd5; k++) wait_os(n);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        check_val("resync_phase", 32'(os_phase), 32'd0);
        cnt = 0;
        do begin
            wait_os(n);
            cnt++;
        end while (!bit_tick && cnt < 40);
        check_val("resync_bit_count", 32'(cnt), 32'd16);

        // div_int=1 clamps to 2
        load_cfg(1, 0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            wait_os(n);
            check_val("clamp_gap", 32'(n), 32'd2);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            en       = ($urandom_range(0, 9) != 0);
            cfg_load = ($urandom_range(0, 99) < 3);
            div_int  = 16'($urandom_range(0, 9));
            div_frac = 4'($urandom_range(0, 15));
            resync   = ($urandom_range(0, 99) < 2);
        end
        @(negedge clk);
        en = 1'b1; cfg_load = 1'b0; resync = 1'b0;
        load_cfg(5, 3, 1'b1);
        repeat (7) wait_os(n);

        // Reset mid-bit
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("reset_outputs", {27'd0, os_tick, bit_tick, mid_tick, cfg_ack, |os_phase}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_os(n);
        check_val("post_reset_gap", 32'(n), 32'd325);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
